uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx.sv | 123 ++++++++++++
 tb/tb_uart_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, parity modes, default frame
// parameters and the parity helper used by both the transmitter and receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

    // Unused upper bits of data must be zero so they do not disturb the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit cycle counter: bit_end pulses on the last cycle of every bit period.
// Cleared by the owning FSM so a frame always starts on a fresh bit boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt_r;

    // Count 0..CLKS_PER_BIT-1, restarting at each boundary or on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_r <= '0;
        end else if (clear || (baud_cnt_r == LAST_CNT)) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
        end
    end

    assign bit_end = (baud_cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// All outputs come straight from flops so the serial line never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_serial
);

    localparam int BCW = $clog2(DATA_BITS) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic ODD_SEL = (PARITY_ODD == PAR_ODD);
    localparam logic HAS_PARITY = (PARITY_EN != 0);

    logic [2:0]           state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [BCW-1:0]       bit_cnt_r;
    logic                 parity_r;
    logic                 tx_serial_r;
    logic                 tx_busy_r;
    logic                 tx_done_r;
    logic                 accept_s;
    logic                 bit_end_s;
    logic [7:0]           data_ext_s;

    // Zero-extend the data word for the parity helper.
    always_comb begin
        data_ext_s = 8'h00;
        data_ext_s[DATA_BITS-1:0] = tx_data;
    end

    assign accept_s = (state_r == ST_IDLE) && tx_start;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept_s),
        .bit_end(bit_end_s)
    );

    // Frame FSM; each branch also loads the line value for the next bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            parity_r    <= 1'b0;
            tx_serial_r <= 1'b1;
            tx_busy_r   <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_serial_r <= 1'b1;
                    tx_busy_r   <= 1'b0;
                    if (tx_start) begin
                        state_r     <= ST_START;
                        shift_r     <= tx_data;
                        parity_r    <= calc_parity(data_ext_s, ODD_SEL);
                        bit_cnt_r   <= '0;
                        tx_serial_r <= 1'b0;
                        tx_busy_r   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r     <= ST_DATA;
                        tx_serial_r <= shift_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r     <= HAS_PARITY ? ST_PARITY : ST_STOP;
                            tx_serial_r <= HAS_PARITY ? parity_r : 1'b1;
                        end else begin
                            shift_r     <= {1'b0, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r   <= bit_cnt_r + BCW'(1);
                            tx_serial_r <= shift_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r     <= ST_STOP;
                        tx_serial_r <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        state_r     <= ST_IDLE;
                        tx_serial_r <= 1'b1;
                        tx_busy_r   <= 1'b0;
                        tx_done_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    tx_serial_r <= 1'b1;
                    tx_busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial = tx_serial_r;
    assign tx_busy   = tx_busy_r;
    assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4: even parity, odd parity and
// no-parity instances share clock and reset.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic [2:0] start;
    logic [7:0] data0, data1, data2;
    logic [2:0] busy, done, ser;

    int vectors;
    int miscompares;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(data0),
        .tx_busy(busy[0]), .tx_done(done[0]), .tx_serial(ser[0]));

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(data1),
        .tx_busy(busy[1]), .tx_done(done[1]), .tx_serial(ser[1]));

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
        .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(data2),
        .tx_busy(busy[2]), .tx_done(done[2]), .tx_serial(ser[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic [7:0] d);
        start[k] = s;
        case (k)
            0: data0 = d;
            1: data1 = d;
            default: data2 = d;
        endcase
    endtask

    // Check one frame cycle by cycle. Entered at a negedge; if !started, the
    // request is raised here and the next posedge is the acceptance edge.
    task automatic frame(input int k, input logic [7:0] d, input logic en,
                         input logic exp_par, input int poke_at, input logic hold,
                         input logic [7:0] next_d, input logic started);
        int f;
        int b;
        logic exp_ser;
        f = CPB * (10 + (en ? 1 : 0));
        if (!started) begin
            drive(k, 1'b1, d);
            @(negedge clk);
        end
        if (hold) drive(k, 1'b1, next_d);
        else      drive(k, 1'b0, ~d);
        for (int j = 1; j <= f + 1; j++) begin
            b = (j - 1) / CPB;
            if (b == 0)                exp_ser = 1'b0;
            else if (b <= 8)           exp_ser = d[b-1];
            else if (en && (b == 9))   exp_ser = exp_par;
            else                       exp_ser = 1'b1;
            chk($sformatf("ser[%0d] d=%h cyc%0d", k, d, j), ser[k], exp_ser);
            chk($sformatf("busy[%0d] d=%h cyc%0d", k, d, j), busy[k], (j <= f));
            chk($sformatf("done[%0d] d=%h cyc%0d", k, d, j), done[k], (j == f + 1));
            if (poke_at != 0 && j == poke_at)     drive(k, 1'b1, 8'hFF);
            if (poke_at != 0 && j == poke_at + 1) drive(k, 1'b0, 8'h00);
            @(negedge clk);
        end
        if (!hold) begin
            chk($sformatf("done_after[%0d] d=%h", k, d), done[k], 1'b0);
            chk($sformatf("busy_after[%0d] d=%h", k, d), busy[k], 1'b0);
            chk($sformatf("ser_after[%0d] d=%h", k, d), ser[k], 1'b1);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        start = 3'b000;
        data0 = 8'hA5;
        data1 = 8'h00;
        data2 = 8'h00;
        start[0] = 1'b1;

        // Reset held with a pending request: line idle, nothing starts.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst_ser[%0d] c%0d", k, c), ser[k], 1'b1);
                chk($sformatf("rst_busy[%0d] c%0d", k, c), busy[k], 1'b0);
                chk($sformatf("rst_done[%0d] c%0d", k, c), done[k], 1'b0);
            end
        end
        reset = 1'b1;

        // First edge after release accepts: 0xA5 even parity, parity bit 0.
        frame(0, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        // Same frame with a 0xFF request poked at N+10, which must be ignored.
        frame(0, 8'hA5, 1'b1, 1'b0, 10, 1'b0, 8'h00, 1'b0);
        // Odd parity: 0x01 -> 0, 0x00 -> 1.
        frame(1, 8'h01, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        frame(1, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0);
        // No parity slot: F = 40.
        frame(2, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        // Back-to-back with tx_start held: 0x3C then 0xC3, both parity 0.
        frame(0, 8'h3C, 1'b1, 1'b0, 0, 1'b1, 8'hC3, 1'b0);
        frame(0, 8'hC3, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1);

        // Mid-frame reset at N+20 while a data-0 bit is on the line.
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (19) @(negedge clk);
        chk("abort_pre_ser", ser[0], 1'b0);
        chk("abort_pre_busy", busy[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("abort_async_ser", ser[0], 1'b1);
        chk("abort_async_busy", busy[0], 1'b0);
        chk("abort_async_done", done[0], 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_hold_ser c%0d", c), ser[0], 1'b1);
            chk($sformatf("abort_hold_done c%0d", c), done[0], 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_release_done", done[0], 1'b0);
        chk("abort_release_ser", ser[0], 1'b1);
        // Fresh 0x5A frame after the abort, even parity 0.
        frame(0, 8'h5A, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
